mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 132 +++++++++++++
 tb/tb_mult_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier among NREQ requesters.
// Grants are combinational; a {valid, index} tag pipeline routes each product back.
module mult_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   parameter int LAT   = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic [WIDTH-1:0]        mul_y,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [WIDTH-1:0]        rsp_y,
   output logic [7:0]              issue_count
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDXW-1:0] ptr_r;
   logic [7:0]      count_r;
   logic            tag_vld_r [LAT];
   logic [IDXW-1:0] tag_idx_r [LAT];

   logic            open_s;
   logic            grant_vld_s;
   logic [IDXW-1:0] grant_idx_s;
   logic [IDXW-1:0] cand_s;
   logic            hit_s;

   // (base + offs) mod NREQ; both operands are below NREQ so one subtraction suffices
   function automatic logic [IDXW-1:0] rr_index(input logic [IDXW-1:0] base,
                                                input logic [IDXW:0]   offs);
      logic [IDXW:0] sum;
      sum = {1'b0, base} + offs;
      if (sum >= (IDXW+1)'(NREQ)) begin
         sum = sum - (IDXW+1)'(NREQ);
      end else begin
         sum = sum;
      end
      return sum[IDXW-1:0];
   endfunction

   // Round-robin search; walking from the far end lets the nearest hit to ptr win
   always_comb begin
      open_s      = enable & ~reset;
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      cand_s      = '0;
      hit_s       = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand_s      = rr_index(ptr_r, (IDXW+1)'(k));
         hit_s       = open_s & req_valid[cand_s];
         grant_idx_s = hit_s ? cand_s : grant_idx_s;
         grant_vld_s = grant_vld_s | hit_s;
      end
   end

   // Grant vector and operand mux toward the multiplier
   always_comb begin
      req_ready = '0;
      mul_a     = '0;
      mul_b     = '0;
      if (grant_vld_s) begin
         req_ready[grant_idx_s] = 1'b1;
         mul_a = req_a[grant_idx_s*WIDTH +: WIDTH];
         mul_b = req_b[grant_idx_s*WIDTH +: WIDTH];
      end else begin
         req_ready = '0;
         mul_a     = '0;
         mul_b     = '0;
      end
   end

   // Tag pipeline mirrors the multiplier latency so the product meets its owner
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_vld_r <= '{default: 1'b0};
         tag_idx_r <= '{default: '0};
      end else begin
         tag_vld_r[0] <= grant_vld_s;
         tag_idx_r[0] <= grant_idx_s;
         for (int s = 1; s < LAT; s++) begin
            tag_vld_r[s] <= tag_vld_r[s-1];
            tag_idx_r[s] <= tag_idx_r[s-1];
         end
      end
   end

   // Priority pointer moves just past the last winner
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (grant_vld_s) begin
         ptr_r <= rr_index(grant_idx_s, (IDXW+1)'(1));
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Issue counter, wraps naturally at 8 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= 8'd0;
      end else if (grant_vld_s) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // Response demux; reset suppresses any stale tag still visible this cycle
   always_comb begin
      rsp_valid = '0;
      rsp_y     = '0;
      if (!reset && tag_vld_r[LAT-1]) begin
         rsp_valid[tag_idx_r[LAT-1]] = 1'b1;
         rsp_y = mul_y;
      end else begin
         rsp_valid = '0;
         rsp_y     = '0;
      end
   end

   assign issue_count = count_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: two instances (LAT=1 and LAT=3) share stimulus and are
// compared each cycle against a cycle-indexed response schedule and a simple RR model.
module tb_mult_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, enable;
   logic [3:0]  req_valid;
   logic [15:0] req_a, req_b;
   logic [3:0]  rdy1, rdy3, rv1, rv3;
   logic [3:0]  ma1, mb1, ma3, mb3, my1, my3, ry1, ry3;
   logic [7:0]  ic1, ic3;
   logic [3:0]  mpipe3 [3];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ptr_m = 0;
   int cnt_m = 0;
   int eg    = -1;
   int lat_m [2] = '{1, 3};
   int due_v [2][8];
   int due_i [2][8];
   int due_p [2][8];

   mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid),
      .req_a(req_a), .req_b(req_b), .req_ready(rdy1), .mul_a(ma1), .mul_b(mb1),
      .mul_y(my1), .rsp_valid(rv1), .rsp_y(ry1), .issue_count(ic1));

   mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(3)) u_dut3 (
      .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid),
      .req_a(req_a), .req_b(req_b), .req_ready(rdy3), .mul_a(ma3), .mul_b(mb3),
      .mul_y(my3), .rsp_valid(rv3), .rsp_y(ry3), .issue_count(ic3));

   function automatic logic [3:0] prod(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] p;
      p = {4'b0, a} * {4'b0, b};
      return p[3:0];
   endfunction

   // external multipliers with latency 1 and 3
   always @(posedge clk) begin
      my1       <= prod(ma1, mb1);
      mpipe3[0] <= prod(ma3, mb3);
      mpipe3[1] <= mpipe3[0];
      mpipe3[2] <= mpipe3[1];
   end
   assign my3 = mpipe3[2];

   function automatic int opa(input int i);
      return int'(req_a[i*WIDTH +: WIDTH]);
   endfunction
   function automatic int opb(input int i);
      return int'(req_b[i*WIDTH +: WIDTH]);
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, expv);
      end
   endtask

   // compare point: negedge, inputs stable
   task automatic cycle();
      int e_rdy, e_a, e_b, e_rv, e_ry, slot;
      @(negedge clk);
      eg = -1;
      if (enable && !reset) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr_m + k) % NREQ;
            if (eg < 0 && req_valid[i]) eg = i;
         end
      end
      e_rdy = (eg < 0) ? 0 : (1 << eg);
      e_a   = (eg < 0) ? 0 : opa(eg);
      e_b   = (eg < 0) ? 0 : opb(eg);
      chk("ready1", int'(rdy1), e_rdy);
      chk("ready3", int'(rdy3), e_rdy);
      chk("mul_a1", int'(ma1), e_a);
      chk("mul_b1", int'(mb1), e_b);
      chk("mul_a3", int'(ma3), e_a);
      chk("mul_b3", int'(mb3), e_b);
      chk("count1", int'(ic1), cnt_m);
      chk("count3", int'(ic3), cnt_m);
      slot = cyc % 8;
      for (int d = 0; d < 2; d++) begin
         e_rv = (!reset && due_v[d][slot] != 0) ? (1 << due_i[d][slot]) : 0;
         e_ry = (!reset && due_v[d][slot] != 0) ? due_p[d][slot] : 0;
         chk(d == 0 ? "rsp_valid1" : "rsp_valid3", d == 0 ? int'(rv1) : int'(rv3), e_rv);
         chk(d == 0 ? "rsp_y1" : "rsp_y3", d == 0 ? int'(ry1) : int'(ry3), e_ry);
      end
   endtask

   // model update at the active edge, then drive point
   task automatic adv();
      @(posedge clk);
      for (int d = 0; d < 2; d++) due_v[d][cyc % 8] = 0;
      if (reset) begin
         ptr_m = 0;
         cnt_m = 0;
         for (int d = 0; d < 2; d++)
            for (int s = 0; s < 8; s++) due_v[d][s] = 0;
      end else if (eg >= 0) begin
         ptr_m = (eg + 1) % NREQ;
         cnt_m = (cnt_m + 1) % 256;
         for (int d = 0; d < 2; d++) begin
            int s;
            s = (cyc + lat_m[d]) % 8;
            due_v[d][s] = 1;
            due_i[d][s] = eg;
            due_p[d][s] = (opa(eg) * opb(eg)) % 16;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic tick();
      cycle();
      adv();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 4'b0000;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic rand_ops();
      req_a = 16'($urandom());
      req_b = 16'($urandom());
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; req_valid = 4'b0000; req_a = 16'h0; req_b = 16'h0;
      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 8; s++) begin due_v[d][s] = 0; due_i[d][s] = 0; due_p[d][s] = 0; end
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // single request, 5*7 = 35 -> 3
      cycle();
      chk("lit_idle_ready", int'(rdy1), 0);
      chk("lit_idle_count", int'(ic1), 0);
      adv();
      req_valid = 4'b0001; req_a = 16'h0005; req_b = 16'h0007;
      cycle();
      chk("lit_single_ready", int'(rdy1), 1);
      chk("lit_single_mul_a", int'(ma1), 5);
      chk("lit_single_mul_b", int'(mb1), 7);
      adv();
      req_valid = 4'b0000;
      cycle();
      chk("lit_single_rsp_valid", int'(rv1), 1);
      chk("lit_single_rsp_y", int'(ry1), 3);
      chk("lit_single_count", int'(ic1), 1);
      adv();
      tick();
      cycle();
      chk("lit_lat3_rsp_valid", int'(rv3), 1);
      chk("lit_lat3_rsp_y", int'(ry3), 3);
      adv();

      // fairness: grant order 0,1,2,3,0,1,2,3
      do_reset();
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         rand_ops();
         cycle();
         chk("lit_fair_grant", int'(rdy1), 1 << (k % 4));
         adv();
      end
      req_valid = 4'b0000;
      cycle();
      chk("lit_fair_count", int'(ic1), 8);
      adv();

      // pointer skip from ptr=2
      do_reset();
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b0011;
      cycle();
      chk("lit_skip_first", int'(rdy1), 1);
      adv();
      cycle();
      chk("lit_skip_second", int'(rdy1), 2);
      adv();

      // enable gating: 3*3 = 9 still returns after enable drops
      do_reset();
      req_valid = 4'b1000; req_a = 16'h3000; req_b = 16'h3000;
      cycle();
      chk("lit_gate_grant", int'(rdy1), 8);
      adv();
      enable = 1'b0; req_valid = 4'b1111;
      cycle();
      chk("lit_gate_ready", int'(rdy1), 0);
      chk("lit_gate_rsp_valid", int'(rv1), 8);
      chk("lit_gate_rsp_y", int'(ry1), 9);
      adv();
      tick();
      tick();
      enable = 1'b1;
      cycle();
      chk("lit_gate_resume", int'(rdy1), 1);
      adv();

      // reset mid-flight on the LAT=3 instance
      do_reset();
      req_valid = 4'b0010; rand_ops();
      tick();
      reset = 1'b1;
      cycle();
      chk("lit_flush_rsp_t1", int'(rv3), 0);
      adv();
      reset = 1'b0; req_valid = 4'b0000;
      cycle();
      chk("lit_flush_rsp_t2", int'(rv3), 0);
      chk("lit_flush_count", int'(ic3), 0);
      adv();
      cycle();
      chk("lit_flush_rsp_t3", int'(rv3), 0);
      adv();
      req_valid = 4'b1111;
      cycle();
      chk("lit_flush_ptr", int'(rdy3), 1);
      adv();

      // 256 grants wrap the counter
      do_reset();
      req_valid = 4'b1111;
      for (int k = 0; k < 256; k++) begin
         rand_ops();
         tick();
      end
      cycle();
      chk("lit_wrap_count", int'(ic1), 0);
      chk("lit_wrap_ptr", int'(rdy1), 1);
      adv();

      // randomized traffic with occasional reset and enable drops
      for (int k = 0; k < 800; k++) begin
         reset     = ($urandom_range(0, 49) == 0);
         enable    = ($urandom_range(0, 7) != 0);
         req_valid = 4'($urandom());
         rand_ops();
         tick();
      end
      reset = 1'b0; enable = 1'b1; req_valid = 4'b0000;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
